pwm_fade_sequencer: RTL and testbench

Scheduler that drives the duty-cycle input of the PWM core to produce a timed fade ("breathing") profile. It ramps duty from a minimum to a maximum, holds, ramps back down, holds, then either loops or stops. Step timing comes from an external one-cycle tick strobe, normally the millisecond output of the clock divider. The block sits between the switch/config logic and the PWM core's duty input, and runs on the same clock as the core.

---
 rtl/pwm_fade_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_pwm_fade_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pwm_fade_sequencer.sv
// pwm_fade_sequencer: drives the PWM core duty input with a timed
// ramp-up / hold / ramp-down / hold "breathing" profile. Timing advances
// only on the external tick strobe. Configuration is captured when a start
// is accepted, so the inputs may change freely while a sequence runs.
module pwm_fade_sequencer #(
  parameter int N  = 8,
  parameter int RW = 16
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          tick_i,
  input  logic          start_i,
  input  logic          stop_i,
  input  logic [N-1:0]  cfg_min_i,
  input  logic [N-1:0]  cfg_max_i,
  input  logic [N-1:0]  cfg_step_i,
  input  logic [RW-1:0] cfg_rate_i,
  input  logic [RW-1:0] cfg_hold_i,
  input  logic          cfg_loop_i,
  output logic [N-1:0]  duty_out_o,
  output logic          busy_o,
  output logic          cycle_done_o,
  output logic          cfg_err_o,
  output logic [2:0]    state_out_o
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_RAMP_UP   = 3'd1;
  localparam logic [2:0] S_HOLD_HIGH = 3'd2;
  localparam logic [2:0] S_RAMP_DOWN = 3'd3;
  localparam logic [2:0] S_HOLD_LOW  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [N-1:0]  duty_q, duty_d;
  logic [RW-1:0] rate_cnt_q, rate_cnt_d;
  logic [RW-1:0] hold_cnt_q, hold_cnt_d;
  logic [N-1:0]  min_q, min_d, max_q, max_d, step_q, step_d;
  logic [RW-1:0] rate_q, rate_d, hold_q, hold_d;
  logic          loop_q, loop_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  // Saturating step values. The upward sum is one bit wider so it clamps
  // at max instead of wrapping; downward uses distance-to-min so it never
  // underflows below zero.
  logic [N:0]   up_sum;
  logic [N-1:0] up_val, dn_gap, dn_val;

  // Saturating next-duty candidates for both ramp directions
  always_comb begin
    up_sum = {1'b0, duty_q} + {1'b0, step_q};
    up_val = (up_sum >= {1'b0, max_q}) ? max_q : up_sum[N-1:0];
    dn_gap = duty_q - min_q;
    dn_val = (dn_gap <= step_q) ? min_q : (duty_q - step_q);
  end

  // Sequencer next-state logic; stop overrides everything, including start
  always_comb begin
    state_d    = state_q;
    duty_d     = duty_q;
    rate_cnt_d = rate_cnt_q;
    hold_cnt_d = hold_cnt_q;
    min_d      = min_q;
    max_d      = max_q;
    step_d     = step_q;
    rate_d     = rate_q;
    hold_d     = hold_q;
    loop_d     = loop_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    if (stop_i) begin
      state_d    = S_IDLE;
      duty_d     = '0;
      rate_cnt_d = '0;
      hold_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (cfg_min_i >= cfg_max_i) begin
              err_d = 1'b1;
            end else begin
              min_d      = cfg_min_i;
              max_d      = cfg_max_i;
              step_d     = (cfg_step_i == '0) ? N'(1) : cfg_step_i;
              rate_d     = cfg_rate_i;
              hold_d     = cfg_hold_i;
              loop_d     = cfg_loop_i;
              duty_d     = cfg_min_i;
              rate_cnt_d = '0;
              hold_cnt_d = '0;
              state_d    = S_RAMP_UP;
            end
          end
        end
        S_RAMP_UP: begin
          if (tick_i) begin
            if (rate_cnt_q == rate_q) begin
              rate_cnt_d = '0;
              duty_d     = up_val;
              if (up_val == max_q) begin
                hold_cnt_d = '0;
                state_d    = S_HOLD_HIGH;
              end
            end else begin
              rate_cnt_d = rate_cnt_q + 1'b1;
            end
          end
        end
        S_HOLD_HIGH: begin
          if (tick_i) begin
            if (hold_cnt_q == hold_q) begin
              rate_cnt_d = '0;
              state_d    = S_RAMP_DOWN;
            end else begin
              hold_cnt_d = hold_cnt_q + 1'b1;
            end
          end
        end
        S_RAMP_DOWN: begin
          if (tick_i) begin
            if (rate_cnt_q == rate_q) begin
              rate_cnt_d = '0;
              duty_d     = dn_val;
              if (dn_val == min_q) begin
                hold_cnt_d = '0;
                state_d    = S_HOLD_LOW;
              end
            end else begin
              rate_cnt_d = rate_cnt_q + 1'b1;
            end
          end
        end
        S_HOLD_LOW: begin
          if (tick_i) begin
            if (hold_cnt_q == hold_q) begin
              done_d     = 1'b1;
              rate_cnt_d = '0;
              state_d    = loop_q ? S_RAMP_UP : S_IDLE;
            end else begin
              hold_cnt_d = hold_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          duty_d  = '0;
        end
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      duty_q     <= '0;
      rate_cnt_q <= '0;
      hold_cnt_q <= '0;
      min_q      <= '0;
      max_q      <= '0;
      step_q     <= '0;
      rate_q     <= '0;
      hold_q     <= '0;
      loop_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      duty_q     <= duty_d;
      rate_cnt_q <= rate_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      min_q      <= min_d;
      max_q      <= max_d;
      step_q     <= step_d;
      rate_q     <= rate_d;
      hold_q     <= hold_d;
      loop_q     <= loop_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign duty_out_o   = duty_q;
  assign busy_o       = busy_q;
  assign cycle_done_o = done_q;
  assign cfg_err_o    = err_q;
  assign state_out_o  = state_q;

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Directed, table-driven bench for pwm_fade_sequencer. Each vector is one
// clock: inputs driven 1 time unit after the rising edge, outputs compared
// 1 time unit after the following rising edge.
module tb_pwm_fade_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick, start, stop;
  logic [7:0]  cfg_min, cfg_max, cfg_step;
  logic [15:0] cfg_rate, cfg_hold;
  logic        cfg_loop;
  logic [7:0]  duty_out;
  logic        busy, cycle_done, cfg_err;
  logic [2:0]  state_out;

  pwm_fade_sequencer #(.N(8), .RW(16)) dut (
    .clk_i(clk), .reset_i(reset), .tick_i(tick), .start_i(start), .stop_i(stop),
    .cfg_min_i(cfg_min), .cfg_max_i(cfg_max), .cfg_step_i(cfg_step),
    .cfg_rate_i(cfg_rate), .cfg_hold_i(cfg_hold), .cfg_loop_i(cfg_loop),
    .duty_out_o(duty_out), .busy_o(busy), .cycle_done_o(cycle_done),
    .cfg_err_o(cfg_err), .state_out_o(state_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start, stop, tick;
    logic [7:0] duty;
    logic [2:0] st;
    logic       busy, cd, err;
  } vec_t;

  vec_t tbl[$];
  int   applied = 0;
  int   miscompares = 0;

  function automatic void add(logic s, logic p, logic t, logic [7:0] d,
                              logic [2:0] st, logic b, logic cd, logic e);
    vec_t v;
    v.start = s; v.stop = p; v.tick = t; v.duty = d;
    v.st = st; v.busy = b; v.cd = cd; v.err = e;
    tbl.push_back(v);
  endfunction

  // Plain tick with expected duty/state, no pulses
  function automatic void tk(logic [7:0] d, logic [2:0] st);
    add(0, 0, 1, d, st, st != 3'd0, 0, 0);
  endfunction

  // rate=2: two ticks that only count, then the stepping tick
  function automatic void step3(logic [7:0] dprev, logic [2:0] sprev,
                                logic [7:0] dnew, logic [2:0] snew);
    tk(dprev, sprev); tk(dprev, sprev); tk(dnew, snew);
  endfunction

  task automatic set_cfg(input int mn, input int mx, input int sp,
                         input int rt, input int hd, input logic lp);
    cfg_min = 8'(mn); cfg_max = 8'(mx); cfg_step = 8'(sp);
    cfg_rate = 16'(rt); cfg_hold = 16'(hd); cfg_loop = lp;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    applied++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic run_table(input string name);
    for (int i = 0; i < tbl.size(); i++) begin
      start = tbl[i].start; stop = tbl[i].stop; tick = tbl[i].tick;
      @(posedge clk); #1;
      start = 0; stop = 0; tick = 0;
      applied++;
      if (duty_out !== tbl[i].duty || state_out !== tbl[i].st ||
          busy !== tbl[i].busy || cycle_done !== tbl[i].cd || cfg_err !== tbl[i].err) begin
        miscompares++;
        $display("FAIL %s[%0d]: got duty=%0d st=%0d busy=%0b cd=%0b err=%0b, expected duty=%0d st=%0d busy=%0b cd=%0b err=%0b",
                 name, i, duty_out, state_out, busy, cycle_done, cfg_err,
                 tbl[i].duty, tbl[i].st, tbl[i].busy, tbl[i].cd, tbl[i].err);
      end
    end
    tbl.delete();
  endtask

  // One drive/sample cycle for the hand-written sequences
  task automatic cyc(input logic s, input logic p, input logic t);
    start = s; stop = p; tick = t;
    @(posedge clk); #1;
    start = 0; stop = 0; tick = 0;
  endtask

  initial begin
    int pulses;
    int waited;
    reset = 1; tick = 0; start = 0; stop = 0;
    set_cfg(0, 0, 0, 0, 0, 0);
    #12;
    chk("reset_duty", duty_out, 0);
    chk("reset_state", state_out, 0);
    chk("reset_busy_cd_err", {busy, cycle_done, cfg_err}, 0);
    @(negedge clk); reset = 0;
    @(posedge clk); #1;

    // Single ramp, rate 0, hold 0, no loop
    set_cfg(10, 40, 10, 0, 0, 0);
    add(1, 0, 0, 10, 1, 1, 0, 0);
    tk(20, 1); tk(30, 1); tk(40, 2); tk(40, 3);
    tk(30, 3); tk(20, 3); tk(10, 4);
    add(0, 0, 1, 10, 0, 0, 1, 0);
    add(0, 0, 1, 10, 0, 0, 0, 0);
    run_table("single_ramp");

    // Saturation with rate 2; a no-tick cycle must not advance anything
    set_cfg(0, 255, 100, 2, 0, 0);
    add(1, 0, 1, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0, 0);
    step3(0, 1, 100, 1); step3(100, 1, 200, 1); step3(200, 1, 255, 2);
    tk(255, 3);
    step3(255, 3, 155, 3); step3(155, 3, 55, 3); step3(55, 3, 0, 4);
    add(0, 0, 1, 0, 0, 0, 1, 0);
    run_table("saturate");

    // Rejected start keeps duty, then step 0 behaves as step 1
    set_cfg(50, 50, 10, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    run_table("reject");
    set_cfg(0, 3, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 1, 0, 0);
    tk(1, 1); tk(2, 1); tk(3, 2); tk(3, 3);
    tk(2, 3); tk(1, 3); tk(0, 4);
    add(0, 0, 1, 0, 0, 0, 1, 0);
    run_table("step_zero");

    // Loop: three cycle_done pulses in 24 ticks (8 ticks per cycle)
    set_cfg(10, 40, 10, 0, 0, 1);
    cyc(1, 0, 0);
    pulses = 0;
    for (int i = 0; i < 24; i++) begin
      cyc(0, 0, 1);
      if (cycle_done) pulses++;
    end
    chk("loop_pulses", pulses, 3);
    chk("loop_still_busy", {busy, state_out}, {1'b1, 3'd1});
    // Advance to HOLD_HIGH, then stop there
    waited = 0;
    while (state_out != 3'd2 && waited < 20) begin
      cyc(0, 0, 1);
      waited++;
    end
    chk("reach_hold_high", state_out, 2);
    cyc(0, 1, 1);
    chk("stop_hold_high", {duty_out, state_out, busy}, {8'd0, 3'd0, 1'b0});
    // start and stop together: stop wins
    cyc(1, 1, 0);
    chk("start_stop_same", {duty_out, state_out, busy, cfg_err}, {8'd0, 3'd0, 2'b00});

    // Config isolation and start while busy
    set_cfg(10, 40, 10, 0, 0, 0);
    cyc(1, 0, 0);
    cyc(0, 0, 1);
    chk("iso_first_step", duty_out, 20);
    set_cfg(0, 25, 10, 0, 0, 0);
    cyc(0, 0, 1);
    chk("iso_latched_max", {duty_out, state_out}, {8'd30, 3'd1});
    set_cfg(0, 255, 10, 0, 0, 0);
    cyc(1, 0, 1);
    chk("busy_start_ignored", {duty_out, state_out, cfg_err}, {8'd40, 3'd2, 1'b0});

    // Asynchronous reset mid-RAMP_UP
    cyc(0, 1, 0);
    set_cfg(10, 40, 10, 0, 0, 0);
    cyc(1, 0, 0);
    cyc(0, 0, 1);
    chk("pre_reset_ramp", {duty_out, state_out}, {8'd20, 3'd1});
    #2 reset = 1;
    #1;
    chk("async_reset", {duty_out, state_out, busy, cycle_done, cfg_err}, 0);
    @(negedge clk); reset = 0;
    cyc(0, 0, 1);
    chk("after_reset_idle", {duty_out, state_out, busy}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
